// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit byte buffer.
package uart_pkg;

    localparam int unsigned UART_TX_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } tx_fifo_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Circular byte FIFO with registered occupancy flags and a sticky overflow flag.
module uart_byte_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = UART_TX_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    input  logic          pop,
    input  logic          ovf_clr,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_overflow;

    logic          w_wr_acc;
    logic          w_pop;
    logic [AW:0]   w_count_nxt;

    // A write while full is dropped regardless of a same-cycle pop.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_pop    = pop & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_wr_acc && !w_pop) begin
            w_count_nxt = r_count + (AW+1)'(1);
        end else if (!w_wr_acc && w_pop) begin
            w_count_nxt = r_count - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            // Set dominates clear.
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign rd_data  = r_mem[r_rd_ptr];
    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer and launch sequencer feeding the UART transmitter over tx_data/tx_start/tx_busy.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = UART_TX_FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic [7:0]    tx_data,
    output logic          tx_start,
    input  logic          tx_busy
);

    tx_fifo_state_t r_state;
    logic [7:0]     r_tx_data;
    logic           r_tx_start;

    logic           w_pop;
    logic [7:0]     w_rd_data;
    logic           w_empty;

    uart_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .nrst     (nrst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .pop      (w_pop),
        .ovf_clr  (ovf_clr),
        .rd_data  (w_rd_data),
        .full     (full),
        .empty    (w_empty),
        .count    (count),
        .overflow (overflow)
    );

    // Pop happens only on the IDLE->LAUNCH transition.
    assign w_pop = (r_state == IDLE) && !w_empty && !tx_busy;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state    <= IDLE;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_tx_data  <= w_rd_data;
                        r_tx_start <= 1'b1;
                        r_state    <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        r_state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign empty    = w_empty;
    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue reference model plus a behavioural transmitter.
module tb_uart_tx_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk;
    logic          nrst;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          ovf_clr;
    logic [7:0]    tx_data;
    logic          tx_start;
    wire           tx_busy;

    logic          hold_busy;
    logic          m_busy;
    logic          m_pend;
    int            m_cnt;
    int            m_len;
    logic          prev_start;
    int            n_starts;
    int            n_cmp;
    int            n_bad;
    logic [7:0]    exp_q[$];

    assign tx_busy = m_busy | hold_busy;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transmitter: accepts tx_start while idle, raises busy the following cycle for m_len cycles.
    always @(negedge clk) begin
        logic bsy;
        bsy = tx_busy;
        if (m_pend) begin
            m_pend = 1'b0;
            m_busy = 1'b1;
            m_cnt  = m_len;
        end else if (m_busy) begin
            if (m_cnt <= 1) m_busy = 1'b0;
            else            m_cnt--;
        end
        if (tx_start) begin
            n_starts++;
            check("start_one_cycle", 32'(prev_start), 32'(0));
            check("start_while_busy", 32'(bsy), 32'(0));
            if (exp_q.size() == 0) check("start_without_data", 32'(exp_q.size()), 32'(1));
            else                   check("tx_data_order", 32'(tx_data), 32'(exp_q.pop_front()));
            m_pend = 1'b1;
        end
        prev_start = tx_start;
    end

    task automatic write_byte(input logic [7:0] d, input bit accepted);
        wr_data = d;
        wr_en   = 1'b1;
        if (accepted) exp_q.push_back(d);
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_busy && !m_pend && empty && !tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_done", 32'(ok), 32'(1));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit got;
        logic [7:0] d;
        n_cmp = 0; n_bad = 0; n_starts = 0;
        m_busy = 1'b0; m_pend = 1'b0; m_cnt = 0; m_len = 3; prev_start = 1'b0;
        hold_busy = 1'b0;
        nrst = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_count", 32'(count), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_full", 32'(full), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        check("rst_tx_start", 32'(tx_start), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        nrst = 1'b1;
        @(negedge clk);

        // Single byte latency
        write_byte(8'hA5, 1'b1);
        check("single_count_after_write", 32'(count), 32'(1));
        check("single_no_start_yet", 32'(tx_start), 32'(0));
        @(negedge clk);
        check("single_start", 32'(tx_start), 32'(1));
        check("single_data", 32'(tx_data), 32'(8'hA5));
        check("single_empty_after_pop", 32'(empty), 32'(1));
        @(negedge clk);
        check("single_start_low", 32'(tx_start), 32'(0));
        drain();

        // Burst order
        m_len = 10;
        p0 = n_starts;
        for (int i = 1; i <= 5; i++) write_byte(8'(i), 1'b1);
        drain();
        check("burst_pulses", 32'(n_starts - p0), 32'(5));

        // Fill with transmitter held busy, overflow on 17th byte
        m_len = 2;
        hold_busy = 1'b1;
        p0 = n_starts;
        for (int i = 0; i < 17; i++) write_byte(8'(8'h10 + i), i < 16);
        check("fill_full", 32'(full), 32'(1));
        check("fill_count", 32'(count), 32'(DEPTH));
        check("fill_overflow", 32'(overflow), 32'(1));
        check("gated_no_start", 32'(n_starts - p0), 32'(0));
        wr_data = 8'hEE; wr_en = 1'b1; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_beats_clr", 32'(overflow), 32'(1));
        check("drop_count", 32'(count), 32'(DEPTH));
        hold_busy = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (tx_start) begin
                got = 1'b1;
                break;
            end
        end
        check("gated_launch_within_2", 32'(got), 32'(1));
        drain();
        check("fill_drained_pulses", 32'(n_starts - p0), 32'(DEPTH));
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'(0));

        // Wrap-around ordering: 20 more bytes
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 10; i++) write_byte(8'($urandom), 1'b1);
            drain();
        end

        // Write and pop in the same cycle with count = 3
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) write_byte(8'(8'h30 + i), 1'b1);
        check("sim_count_pre", 32'(count), 32'(3));
        hold_busy = 1'b0;
        d = 8'($urandom);
        write_byte(d, 1'b1);
        check("sim_count_kept", 32'(count), 32'(3));
        check("sim_start", 32'(tx_start), 32'(1));
        drain();

        // Reset in WAIT_DONE with four bytes queued
        m_len = 30;
        for (int i = 0; i < 5; i++) write_byte(8'(8'h50 + i), 1'b1);
        check("mid_count", 32'(count), 32'(4));
        check("mid_tx_busy", 32'(tx_busy), 32'(1));
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        exp_q.delete();
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_empty", 32'(empty), 32'(1));
        check("mid_rst_start", 32'(tx_start), 32'(0));
        check("mid_rst_data", 32'(tx_data), 32'(0));
        check("mid_rst_ovf", 32'(overflow), 32'(0));
        p0 = n_starts;
        repeat (40) @(negedge clk);
        check("mid_no_launch", 32'(n_starts - p0), 32'(0));
        m_len = 3;
        write_byte(8'h77, 1'b1);
        drain();
        check("mid_relaunch", 32'(n_starts - p0), 32'(1));

        // Randomised bursts
        for (int b = 0; b < 8; b++) begin
            m_len = int'($urandom_range(1, 8));
            for (int i = 0; i < int'($urandom_range(1, 12)); i++) begin
                write_byte(8'($urandom), 1'b1);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            drain();
        end
        check("rand_no_overflow", 32'(overflow), 32'(0));
        check("rand_final_count", 32'(count), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and launch sequencer directly upstream of the UART serial transmitter.
- Producers (tinyZuse core, status/debug formatters) write bytes at any rate.
- The block stores them in a circular FIFO and hands them to the transmitter one at a time over its tx_data/tx_start/tx_busy handshake.
- Decouples the core from baud timing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock
- nrst  input  1  reset, synchronous, active-low
- wr_data  input  8  byte to enqueue
- wr_en  input  1  write strobe; one byte per cycle
- full  output  1  FIFO holds DEPTH bytes
- empty  output  1  FIFO holds 0 bytes
- count  output  AW+1  current occupancy, 0..DEPTH
- overflow  output  1  sticky: a write was dropped
- ovf_clr  input  1  clears overflow
- tx_data  output  8  byte presented to transmitter
- tx_start  output  1  one-cycle launch strobe to transmitter
- tx_busy  input  1  transmitter busy; transmitter accepts tx_start only while low and raises busy the following cycle

Behaviour:
- Reset (nrst low at clk edge):
  - Pointers, count = 0; full = 0; empty = 1; overflow = 0.
  - tx_start = 0; tx_data = 8'h00; state = IDLE.
  - Storage contents are don't-care.
  - Reset mid-transfer abandons the queued bytes and the in-flight handshake. No tx_start is issued until new data arrives.
- All outputs are registered. full, empty and count derive from the registered count.
- Write:
  - Accepted when wr_en = 1 and full = 0; stored at wr_ptr, which then increments modulo DEPTH.
  - If wr_en = 1 and full = 1, the byte is dropped and overflow is set.
  - A write while full is dropped even if a pop occurs in the same cycle.
- overflow:
  - Set by a dropped write; cleared by ovf_clr.
  - If set and clear happen in the same cycle, set wins.
- Pop and count:
  - A pop occurs only on the IDLE->LAUNCH transition. It reads the entry at rd_ptr into tx_data and increments rd_ptr modulo DEPTH.
  - Accepted write plus pop in the same cycle leaves count unchanged.
  - Write alone: count+1. Pop alone: count-1.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
  - IDLE: if empty = 0 and tx_busy = 0, pop and go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_start = 1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY: tx_start = 0; wait for tx_busy = 1, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: wait for tx_busy = 0, then go to IDLE.
- tx_data is held stable from LAUNCH until the next pop.
- tx_start is asserted only in LAUNCH.
- Latency:
  - A byte written at edge N into an empty FIFO with the transmitter idle is popped at edge N+1.
  - tx_start is high during the cycle after edge N+1.
  - The transmitter samples tx_start at edge N+2.
- Back-to-back: after tx_busy falls, IDLE relaunches on the next edge.
- Minimum gap: 2 cycles between tx_busy low and the transmitter accepting the next byte.
- Ordering is strict FIFO. No byte is duplicated or skipped, including across pointer wrap-around.

Decomposition:
- Shared package uart_pkg:
  - tx_fifo_state_t enum {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE}
  - UART_TX_FIFO_DEPTH default constant = 16
- One natural sub-module: uart_byte_fifo.
  - Contains storage, pointers, count, full/empty and overflow logic.
  - Exposes a pop strobe and the rd data.
  - The top holds the FSM and the tx_data register.

Test Plan:
- Single byte: write 8'hA5 at edge N, tx_busy = 0 -> tx_data = 8'hA5 and tx_start high for exactly one cycle after edge N+1; empty = 1 after pop.
- Burst order: write 8'h01..8'h05 back-to-back with a transmitter model (busy for 10 cycles per byte) -> tx_data sequence 01,02,03,04,05; exactly 5 tx_start pulses.
- Fill, overflow and wrap:
  - Hold tx_busy = 1 and write 17 bytes (DEPTH = 16) -> full = 1, count = 16, overflow = 1, 17th byte absent.
  - Release busy -> 16 bytes out in order.
  - Then ovf_clr -> overflow = 0.
  - Write 20 more bytes -> wrap ordering correct.
- Simultaneous events: with count = 3 in IDLE, write and pop in the same cycle -> count stays 3; ovf_clr coinciding with a dropped write -> overflow stays 1.
- Busy gating: tx_busy = 1 while the FIFO is non-empty -> no tx_start; tx_busy falls -> tx_start within 2 cycles.
- Reset mid-operation: pulse nrst low in WAIT_DONE with count = 4 -> next cycle count = 0, empty = 1, tx_start = 0, tx_data = 8'h00, overflow = 0; no further launches until a new write.
